// File: rtl/rf_wb_queue_pkg.sv
// rtl/rf_wb_queue_pkg.sv - shared writeback entry layout and default widths
package rf_wb_queue_pkg;

    localparam int RF_AW     = 5;
    localparam int RF_DW     = 32;
    localparam int WBQ_DEPTH = 4;

    // One pending register-file write; also used by writeback stage declarations
    typedef struct packed {
        logic [RF_AW-1:0] wR;
        logic [RF_DW-1:0] wD;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_queue_if.sv
// rtl/rf_wb_queue_if.sv - writeback queue handshake, drain and forwarding bundle
import rf_wb_queue_pkg::*;

interface rf_wb_queue_if #(
    parameter int DEPTH = WBQ_DEPTH,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Writeback side
    logic          in_valid_i;
    logic          in_ready_o;
    logic [AW-1:0] in_wR_i;
    logic [DW-1:0] in_wD_i;

    // Register-file write port
    logic          rf_grant_i;
    logic          rf_we_o;
    logic [AW-1:0] rf_wR_o;
    logic [DW-1:0] rf_wD_o;

    // Decode-stage forwarding
    logic [AW-1:0] rR1_i;
    logic [AW-1:0] rR2_i;
    logic          fwd1_hit_o;
    logic [DW-1:0] fwd1_data_o;
    logic          fwd2_hit_o;
    logic [DW-1:0] fwd2_data_o;

    // Occupancy
    logic [CW-1:0] count_o;
    logic          full_o;
    logic          empty_o;

    modport slave (
        input  in_valid_i, in_wR_i, in_wD_i, rf_grant_i, rR1_i, rR2_i,
        output in_ready_o, rf_we_o, rf_wR_o, rf_wD_o,
               fwd1_hit_o, fwd1_data_o, fwd2_hit_o, fwd2_data_o,
               count_o, full_o, empty_o
    );

    modport master (
        output in_valid_i, in_wR_i, in_wD_i, rf_grant_i, rR1_i, rR2_i,
        input  in_ready_o, rf_we_o, rf_wR_o, rf_wD_o,
               fwd1_hit_o, fwd1_data_o, fwd2_hit_o, fwd2_data_o,
               count_o, full_o, empty_o
    );

endinterface

// File: rtl/rf_wb_queue_fwd_match.sv
// rtl/rf_wb_queue_fwd_match.sv - youngest-match search over pending queue entries
import rf_wb_queue_pkg::*;

module rf_wb_fwd_match #(
    parameter int DEPTH = WBQ_DEPTH,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]         vld_i,
    input  logic [DEPTH-1:0][AW-1:0] ent_wr_i,
    input  logic [DEPTH-1:0][DW-1:0] ent_wd_i,
    input  logic [PW-1:0]            wr_ptr_i,
    input  logic [AW-1:0]            rd_addr_i,
    output logic                     hit_o,
    output logic [DW-1:0]            data_o
);

    logic [PW-1:0] idx;

    // Walk from the oldest slot (wr_ptr-DEPTH) to the youngest (wr_ptr-1); later matches override
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        if (rd_addr_i != '0) begin
            for (int k = DEPTH; k >= 1; k--) begin
                idx = PW'(wr_ptr_i - PW'(k));
                if (vld_i[idx] && (ent_wr_i[idx] == rd_addr_i)) begin
                    hit_o  = 1'b1;
                    data_o = ent_wd_i[idx];
                end
            end
        end
    end

endmodule

// File: rtl/rf_wb_queue.sv
// rtl/rf_wb_queue.sv - in-order writeback FIFO draining into the register-file write port
import rf_wb_queue_pkg::*;

module rf_wb_queue #(
    parameter int DEPTH = WBQ_DEPTH,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic         clk_i,
    input  logic         rst_i,
    rf_wb_queue_if.slave q
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [DEPTH-1:0][AW-1:0] ent_wr_q;
    logic [DEPTH-1:0][DW-1:0] ent_wd_q;
    logic [DEPTH-1:0]         ent_vld;

    logic full, empty;
    logic enq_fire, enq_store, deq;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Register x0 results are accepted to keep the pipeline moving but never stored
    assign enq_fire  = q.in_valid_i & ~full;
    assign enq_store = enq_fire & (q.in_wR_i != '0);
    assign deq       = ~empty & q.rf_grant_i;

    // Next-state pointers and occupancy; simultaneous enqueue/dequeue leaves count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_store) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({enq_store, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset discards anything still pending
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; validity comes from count, so the payload needs no reset
    always_ff @(posedge clk_i) begin
        if (enq_store) begin
            ent_wr_q[wr_ptr_q] <= q.in_wR_i;
            ent_wd_q[wr_ptr_q] <= q.in_wD_i;
        end
    end

    // A slot is pending when its distance from the read pointer is below the count
    always_comb begin
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_vld[i] = ({1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q);
        end
    end

    assign q.in_ready_o = ~full;
    assign q.count_o    = count_q;
    assign q.full_o     = full;
    assign q.empty_o    = empty;

    assign q.rf_we_o = deq;
    assign q.rf_wR_o = empty ? '0 : ent_wr_q[rd_ptr_q];
    assign q.rf_wD_o = empty ? '0 : ent_wd_q[rd_ptr_q];

    rf_wb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd1 (
        .vld_i     (ent_vld),
        .ent_wr_i  (ent_wr_q),
        .ent_wd_i  (ent_wd_q),
        .wr_ptr_i  (wr_ptr_q),
        .rd_addr_i (q.rR1_i),
        .hit_o     (q.fwd1_hit_o),
        .data_o    (q.fwd1_data_o)
    );

    rf_wb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd2 (
        .vld_i     (ent_vld),
        .ent_wr_i  (ent_wr_q),
        .ent_wd_i  (ent_wd_q),
        .wr_ptr_i  (wr_ptr_q),
        .rd_addr_i (q.rR2_i),
        .hit_o     (q.fwd2_hit_o),
        .data_o    (q.fwd2_data_o)
    );

endmodule

// File: tb/tb_rf_wb_queue.sv
// tb/tb_rf_wb_queue.sv - randomized and directed check of rf_wb_queue against a queue model
import rf_wb_queue_pkg::*;

module tb_rf_wb_queue;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_wb_queue_if #(.DEPTH(DEPTH), .AW(RF_AW), .DW(RF_DW)) bus ();

    rf_wb_queue #(.DEPTH(DEPTH), .AW(RF_AW), .DW(RF_DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .q     (bus)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    wb_entry_t mq[$];
    wb_entry_t dut_writes[$];
    wb_entry_t stim[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pending writes as a plain FIFO list, updated with the inputs seen at each edge
    always @(posedge clk) begin
        bit deq_m, enq_m;
        if (rst) begin
            mq.delete();
        end else begin
            deq_m = (mq.size() > 0) && bus.rf_grant_i;
            enq_m = bus.in_valid_i && (mq.size() < DEPTH) && (bus.in_wR_i != 0);
            if (deq_m) void'(mq.pop_front());
            if (enq_m) mq.push_back('{wR: bus.in_wR_i, wD: bus.in_wD_i});
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin
        int n;
        bit h1, h2;
        logic [RF_DW-1:0] d1, d2;
        if (cmp_en) begin
            n = mq.size();
            h1 = 0; d1 = '0; h2 = 0; d2 = '0;
            for (int i = 0; i < n; i++) begin
                if (bus.rR1_i != 0 && mq[i].wR == bus.rR1_i) begin h1 = 1; d1 = mq[i].wD; end
                if (bus.rR2_i != 0 && mq[i].wR == bus.rR2_i) begin h2 = 1; d2 = mq[i].wD; end
            end
            chk("count", 64'(bus.count_o), 64'(n));
            chk("full", 64'(bus.full_o), 64'(n == DEPTH));
            chk("empty", 64'(bus.empty_o), 64'(n == 0));
            chk("in_ready", 64'(bus.in_ready_o), 64'(n != DEPTH));
            chk("rf_we", 64'(bus.rf_we_o), 64'((n > 0) && bus.rf_grant_i));
            chk("rf_wR", 64'(bus.rf_wR_o), (n > 0) ? 64'(mq[0].wR) : 64'd0);
            chk("rf_wD", 64'(bus.rf_wD_o), (n > 0) ? 64'(mq[0].wD) : 64'd0);
            chk("fwd1_hit", 64'(bus.fwd1_hit_o), 64'(h1));
            chk("fwd1_data", 64'(bus.fwd1_data_o), 64'(d1));
            chk("fwd2_hit", 64'(bus.fwd2_hit_o), 64'(h2));
            chk("fwd2_data", 64'(bus.fwd2_data_o), 64'(d2));
            if (bus.rf_we_o) dut_writes.push_back('{wR: bus.rf_wR_o, wD: bus.rf_wD_o});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [RF_AW-1:0] a, input logic [RF_DW-1:0] d);
        bus.in_valid_i = 1'b1;
        bus.in_wR_i    = a;
        bus.in_wD_i    = d;
        tick();
        bus.in_valid_i = 1'b0;
    endtask

    initial begin
        logic [RF_AW-1:0] ra;
        logic [RF_DW-1:0] rd;
        bus.in_valid_i = 1'b0;
        bus.in_wR_i    = '0;
        bus.in_wD_i    = '0;
        bus.rf_grant_i = 1'b0;
        bus.rR1_i      = '0;
        bus.rR2_i      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_en = 1'b1;
        bus.rf_grant_i = 1'b1;
        bus.rR1_i = 5'd1;
        #1;
        chk("rst_count", 64'(bus.count_o), 64'd0);
        chk("rst_empty", 64'(bus.empty_o), 64'd1);
        chk("rst_full", 64'(bus.full_o), 64'd0);
        chk("rst_ready", 64'(bus.in_ready_o), 64'd1);
        chk("rst_we", 64'(bus.rf_we_o), 64'd0);
        chk("rst_hit1", 64'(bus.fwd1_hit_o), 64'd0);
        chk("rst_data1", 64'(bus.fwd1_data_o), 64'd0);

        // Reset mid-operation
        bus.rf_grant_i = 1'b0;
        enq(5'd1, 32'h11); enq(5'd2, 32'h22); enq(5'd3, 32'h33);
        #1;
        chk("t1_count3", 64'(bus.count_o), 64'd3);
        chk("t1_hit_pre", 64'(bus.fwd1_hit_o), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.rf_grant_i = 1'b1;
        #1;
        chk("t1_count", 64'(bus.count_o), 64'd0);
        chk("t1_empty", 64'(bus.empty_o), 64'd1);
        chk("t1_we", 64'(bus.rf_we_o), 64'd0);
        chk("t1_hit", 64'(bus.fwd1_hit_o), 64'd0);
        tick();
        chk("t1_we_after", 64'(bus.rf_we_o), 64'd0);

        // Fill, overflow attempt, ordered drain
        bus.rf_grant_i = 1'b0;
        for (int i = 1; i <= 4; i++) enq(5'(i), 32'(i * 'h11));
        #1;
        chk("t2_full", 64'(bus.full_o), 64'd1);
        chk("t2_ready", 64'(bus.in_ready_o), 64'd0);
        bus.in_valid_i = 1'b1; bus.in_wR_i = 5'd9; bus.in_wD_i = 32'h99;
        tick();
        bus.in_valid_i = 1'b0;
        #1;
        chk("t2_count_held", 64'(bus.count_o), 64'd4);
        bus.rf_grant_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("t2_we", 64'(bus.rf_we_o), 64'd1);
            chk("t2_wR", 64'(bus.rf_wR_o), 64'(i));
            chk("t2_wD", 64'(bus.rf_wD_o), 64'(i * 'h11));
            tick();
        end
        #1;
        chk("t2_empty", 64'(bus.empty_o), 64'd1);

        // Youngest-match forwarding
        bus.rf_grant_i = 1'b0;
        enq(5'd5, 32'hAAAA); enq(5'd5, 32'hBBBB);
        bus.rR1_i = 5'd5; bus.rR2_i = 5'd6;
        #1;
        chk("t3_hit1", 64'(bus.fwd1_hit_o), 64'd1);
        chk("t3_data1", 64'(bus.fwd1_data_o), 64'hBBBB);
        chk("t3_hit2", 64'(bus.fwd2_hit_o), 64'd0);
        chk("t3_data2", 64'(bus.fwd2_data_o), 64'd0);
        bus.rf_grant_i = 1'b1;
        tick(); tick();
        #1;
        chk("t3_empty", 64'(bus.empty_o), 64'd1);

        // x0 results are swallowed and never forwarded
        bus.rR1_i = 5'd0;
        bus.in_valid_i = 1'b1; bus.in_wR_i = 5'd0; bus.in_wD_i = 32'hDEAD;
        #1;
        chk("t4_ready", 64'(bus.in_ready_o), 64'd1);
        tick();
        bus.in_valid_i = 1'b0;
        #1;
        chk("t4_count", 64'(bus.count_o), 64'd0);
        chk("t4_we", 64'(bus.rf_we_o), 64'd0);
        chk("t4_hit", 64'(bus.fwd1_hit_o), 64'd0);

        // Continuous streaming at DEPTH-1 occupancy across pointer wrap
        bus.rf_grant_i = 1'b0;
        dut_writes.delete();
        stim.delete();
        for (int i = 0; i < DEPTH - 1; i++) begin
            ra = 5'($urandom_range(1, 31)); rd = $urandom;
            stim.push_back('{wR: ra, wD: rd});
            enq(ra, rd);
        end
        bus.rf_grant_i = 1'b1;
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ra = 5'($urandom_range(1, 31)); rd = $urandom;
            bus.in_wR_i = ra; bus.in_wD_i = rd;
            stim.push_back('{wR: ra, wD: rd});
            #1;
            chk("t5_count", 64'(bus.count_o), 64'(DEPTH - 1));
            tick();
        end
        bus.in_valid_i = 1'b0;
        repeat (DEPTH) tick();
        chk("t5_nwrites", 64'(dut_writes.size()), 64'(stim.size()));
        for (int i = 0; i < stim.size() && i < dut_writes.size(); i++) begin
            chk("t5_order", 64'(dut_writes[i]), 64'(stim[i]));
        end

        // Grant stall holds the single entry and its forwarding
        bus.rf_grant_i = 1'b0;
        enq(5'd7, 32'h77);
        bus.rR1_i = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t6_we_stall", 64'(bus.rf_we_o), 64'd0);
            chk("t6_hit", 64'(bus.fwd1_hit_o), 64'd1);
            chk("t6_data", 64'(bus.fwd1_data_o), 64'h77);
            tick();
        end
        bus.rf_grant_i = 1'b1;
        #1;
        chk("t6_we", 64'(bus.rf_we_o), 64'd1);
        chk("t6_wD", 64'(bus.rf_wD_o), 64'h77);
        tick();
        chk("t6_empty", 64'(bus.empty_o), 64'd1);
        chk("t6_hit_gone", 64'(bus.fwd1_hit_o), 64'd0);

        // Random traffic with occasional resets, checked every cycle by the model
        for (int i = 0; i < 800; i++) begin
            bus.in_valid_i = ($urandom_range(0, 2) != 0);
            bus.in_wR_i    = 5'($urandom_range(0, 7));
            bus.in_wD_i    = $urandom;
            bus.rf_grant_i = ($urandom_range(0, 3) != 0);
            bus.rR1_i      = 5'($urandom_range(0, 7));
            bus.rR2_i      = 5'($urandom_range(0, 7));
            rst            = ($urandom_range(0, 96) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
